// File: rtl/prng_word_reader.sv
// prng_word_reader: requests bytes from prng_top, packs four of them LSB-first
// into a 32-bit word and queues the word in a small registered FIFO that
// drains over a valid/ready stream.
module prng_word_reader #(
  parameter int FIFO_DEPTH = 4,   // power of two, >= 2
  parameter int REQ_GAP    = 6,   // min cycles between get_random pulses, >= 5
  parameter int BYTE_LAT   = 1    // get_random cycle -> byte 0 valid, >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        get_random,
  input  logic [7:0]  rng_byte,
  output logic        word_valid,
  output logic [31:0] word_data,
  input  logic        word_ready,
  output logic [15:0] word_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [15:0]   elapsed_q, elapsed_d;   // cycles since the last REQ cycle
  logic [1:0]    byte_q, byte_d;         // index of the next byte to capture
  logic [23:0]   word_q, word_d;         // bytes 0..2 of the word in progress
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [15:0]   word_count_q;

  logic        launch;
  logic        wr_en;
  logic        pop;
  logic [31:0] wr_data;

  // Launch points are IDLE and the end of GAP; the previous word has already
  // been written there, so nothing is in flight and a free slot is enough.
  assign launch  = run && (count_q < (AW+1)'(FIFO_DEPTH));
  assign wr_en   = (state_q == S_CAP) && (byte_q == 2'd3);
  assign wr_data = {rng_byte, word_q};
  assign pop     = word_valid && word_ready;

  assign get_random = (state_q == S_REQ);
  assign word_valid = (count_q != '0);
  assign word_data  = word_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign word_count = word_count_q;

  // Request/capture sequencing and the elapsed-cycle timer.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    word_d    = word_q;
    elapsed_d = (elapsed_q == 16'hFFFF) ? elapsed_q : elapsed_q + 16'd1;
    case (state_q)
      S_IDLE: if (launch) state_d = S_REQ;
      S_REQ: begin
        byte_d  = 2'd0;
        state_d = (BYTE_LAT == 1) ? S_CAP : S_WAIT;
      end
      S_WAIT: if (elapsed_q >= 16'(BYTE_LAT - 1)) state_d = S_CAP;
      S_CAP: begin
        byte_d = byte_q + 2'd1;
        case (byte_q)
          2'd0:    word_d[7:0]   = rng_byte;
          2'd1:    word_d[15:8]  = rng_byte;
          2'd2:    word_d[23:16] = rng_byte;
          default: state_d       = S_GAP;
        endcase
      end
      S_GAP: if (elapsed_q >= 16'(REQ_GAP - 1)) state_d = launch ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Timer reads zero during the REQ cycle itself.
    if (state_d == S_REQ) elapsed_d = 16'd0;
  end

  // FSM, capture and FIFO bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      elapsed_q    <= 16'd0;
      byte_q       <= 2'd0;
      word_q       <= 24'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      word_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      elapsed_q    <= elapsed_d;
      byte_q       <= byte_d;
      word_q       <= word_d;
      word_count_q <= wr_en ? word_count_q + 16'd1 : word_count_q;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are only visible through word_data while valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_prng_word_reader.sv
// tb_prng_word_reader: plays prng_top with a random byte stream, keeps a
// queue-level model of requests, words and FIFO contents, and compares the
// DUT against it every cycle, plus directed scenarios with literal checks.
module tb_prng_word_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        get_random;
  logic [7:0]  rng_byte = 8'h00;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready = 1'b0;
  logic [15:0] word_count;

  prng_word_reader #(.FIFO_DEPTH(4), .REQ_GAP(6), .BYTE_LAT(1)) dut (
    .clk(clk), .rst(rst), .run(run), .get_random(get_random),
    .rng_byte(rng_byte), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int npulse = 0;
  int last_pulse = -100;
  bit ovr_arm = 1'b0;
  bit prev_valid = 1'b0;
  logic [15:0] mcnt = 16'd0;
  logic [7:0]  hist [int];
  logic [7:0]  ovr [$];
  logic [31:0] fq [$];
  int          iq [$];
  int          pulses [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Byte source: scripted bytes when queued, otherwise random.
  always @(negedge clk) begin
    if (ovr.size() != 0) rng_byte = ovr.pop_front();
    else rng_byte = 8'($urandom);
  end

  // Reference model and per-cycle compare, just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    hist[cyc-1] = rng_byte;
    if (rst) begin
      fq.delete();
      iq.delete();
      mcnt = 16'd0;
      last_pulse = -100;
    end else begin
      if (prev_valid && word_ready) void'(fq.pop_front());
      if (iq.size() != 0 && iq[0] + 4 == cyc - 1) begin
        int t;
        t = iq.pop_front();
        fq.push_back({hist[t+4], hist[t+3], hist[t+2], hist[t+1]});
        mcnt = mcnt + 16'd1;
      end
    end
    chk("word_valid", 32'(word_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) chk("word_data", word_data, fq[0]);
    else chk("word_data_idle", word_data, 32'h0);
    chk("word_count", 32'(word_count), 32'(mcnt));
    if (get_random) begin
      chk("req_spacing", 32'((cyc - last_pulse) >= 6), 32'd1);
      chk("req_slot", 32'((fq.size() + iq.size()) < 4), 32'd1);
      iq.push_back(cyc);
      pulses.push_back(cyc);
      last_pulse = cyc;
      npulse++;
      if (ovr_arm) begin
        ovr_arm = 1'b0;
        ovr.push_back(8'h55);
        ovr.push_back(8'hcd);
        ovr.push_back(8'h8a);
        ovr.push_back(8'h46);
        ovr.push_back(8'h02);
      end
    end
    prev_valid = (fq.size() != 0);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_pulse(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (get_random) begin
        t = cyc;
        return;
      end
    end
    chk("pulse_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n0;
    // 1. reset for three cycles, then one scripted word
    repeat (3) @(negedge clk);
    step(0);
    chk("rst_get_random", 32'(get_random), 32'd0);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_data", word_data, 32'h0);
    chk("rst_count", 32'(word_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ovr_arm = 1'b1;
    run = 1'b1;
    wait_pulse(t);
    step(4);
    chk("t1_not_yet_valid", 32'(word_valid), 32'd0);
    step(1);
    chk("t1_valid", 32'(word_valid), 32'd1);
    chk("t1_data", word_data, 32'h02468acd);
    chk("t1_count", 32'(word_count), 32'd1);

    // 2. stalled consumer: exactly four requests, then drain in order
    do_reset();
    n0 = npulse;
    run = 1'b1;
    word_ready = 1'b0;
    repeat (60) @(negedge clk);
    chk("t2_pulses_full", 32'(npulse - n0), 32'd4);
    chk("t2_count", 32'(word_count), 32'd4);
    word_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("t2_resumed", 32'((npulse - n0) > 4), 32'd1);

    // 3. free-flowing consumer: request period exactly six cycles
    do_reset();
    pulses.delete();
    run = 1'b1;
    word_ready = 1'b1;
    repeat (80) @(negedge clk);
    chk("t3_enough_pulses", 32'(pulses.size() >= 10), 32'd1);
    for (int i = 1; i < pulses.size(); i++)
      chk("t3_period", 32'(pulses[i] - pulses[i-1]), 32'd6);

    // 4. reset in the middle of a capture discards the partial word
    do_reset();
    run = 1'b1;
    wait_pulse(t);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1);
    chk("t4_count", 32'(word_count), 32'd0);
    chk("t4_valid", 32'(word_valid), 32'd0);
    repeat (10) @(negedge clk);
    chk("t4_count_later", 32'(word_count), 32'd0);
    run = 1'b1;
    wait_pulse(t);
    step(5);
    chk("t4_clean_word", 32'(word_count), 32'd1);

    // 5. run dropped during capture: word completes, no new request
    do_reset();
    run = 1'b1;
    wait_pulse(t);
    repeat (3) @(negedge clk);
    run = 1'b0;
    n0 = npulse;
    repeat (30) @(negedge clk);
    chk("t5_no_pulse", 32'(npulse - n0), 32'd0);
    chk("t5_count", 32'(word_count), 32'd1);

    // 6. word_count wrap via backdoor preload
    do_reset();
    word_ready = 1'b1;
    @(negedge clk);
    force dut.word_count_q = 16'hFFFF;
    mcnt = 16'hFFFF;
    @(negedge clk);
    release dut.word_count_q;
    step(1);
    chk("t6_preload", 32'(word_count), 32'h0000FFFF);
    @(negedge clk);
    run = 1'b1;
    wait_pulse(t);
    step(5);
    chk("t6_wrap", 32'(word_count), 32'h0);

    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      run = ($urandom_range(0, 9) != 0);
      word_ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
